// File: rtl/adc_sample_packetizer_if.sv
// AXI4-Stream bundle for the ADC sample packetizer output.
// The master drives payload and tvalid; the slave returns tready.
interface adc_sample_packetizer_if #(
  parameter int AXI_DATA_WIDTH = 64
);
  logic [AXI_DATA_WIDTH-1:0]   tdata;
  logic [AXI_DATA_WIDTH/8-1:0] tkeep;
  logic                        tvalid;
  logic                        tready;
  logic                        tlast;
  logic                        tuser;

  modport master (
    output tdata, tkeep, tvalid, tlast, tuser,
    input  tready
  );

  modport slave (
    input  tdata, tkeep, tvalid, tlast, tuser,
    output tready
  );
endinterface

// File: rtl/adc_sample_packetizer.sv
// ADC sample packetizer: captures NUM_CH x SAMPLE_WIDTH words while the
// synchronised enable is high, packs them (dense or counter-tagged) into
// AXI_DATA_WIDTH beats, frames them with tlast/tuser, buffers them in a
// first-word-fall-through FIFO and streams them out on AXI4-Stream.
// Optional build macro: ADC_TEST_PATTERN_EN replaces the ADC data with a
// counting pattern when test_pattern_sel is high.
module adc_sample_packetizer #(
  parameter int NUM_CH          = 2,
  parameter int SAMPLE_WIDTH    = 16,
  parameter int AXI_DATA_WIDTH  = 64,
  parameter int FIFO_DEPTH_LOG2 = 9,
  parameter int FRAME_LEN_WIDTH = 16
) (
  input  logic                              aclk,
  input  logic                              aresetn,
  input  logic                              adc_enable,
  input  logic [NUM_CH*SAMPLE_WIDTH-1:0]    adc_data,
  input  logic                              adc_valid,
  input  logic [FRAME_LEN_WIDTH-1:0]        frame_len,
  input  logic                              tag_mode,
  input  logic                              test_pattern_sel,
  adc_sample_packetizer_if.master           m_axis,
  output logic                              overflow,
  input  logic                              overflow_clr,
  output logic [31:0]                       sample_count,
  output logic [FIFO_DEPTH_LOG2:0]          fifo_level
);
  localparam int WORD_W  = NUM_CH * SAMPLE_WIDTH;
  localparam int LANES   = AXI_DATA_WIDTH / WORD_W;
  localparam int IDX_W   = $clog2(LANES + 1);
  localparam int KEEP_W  = AXI_DATA_WIDTH / 8;
  localparam int DEPTH   = 1 << FIFO_DEPTH_LOG2;
  localparam int LEVEL_W = FIFO_DEPTH_LOG2 + 1;
  localparam int ENTRY_W = AXI_DATA_WIDTH + KEEP_W + 2;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_FLUSH = 2'd2} state_t;

  state_t                      state_q;
  logic                        en_r_q, en_rr_q;
  logic [FRAME_LEN_WIDTH-1:0]  frame_len_q, beat_cnt_q;
  logic                        tag_mode_q;
  logic [31:0]                 sample_count_q;
  logic [AXI_DATA_WIDTH-1:0]   pack_data_q;
  logic [IDX_W-1:0]            pack_idx_q;
  logic [AXI_DATA_WIDTH-1:0]   held_q;
  logic                        held_valid_q, held_last_q;
  logic                        sof_q;
  logic                        overflow_q;

  logic [WORD_W-1:0]           in_word;
  logic [AXI_DATA_WIDTH-1:0]   pack_data_d, tag_beat, complete_beat, push_beat;
  logic [KEEP_W-1:0]           partial_keep, push_keep;
  logic                        accept, complete, frame_end, partial_valid;
  logic                        push_req, push_last;
  logic [ENTRY_W-1:0]          push_entry;

  // FIFO storage and pointers
  logic [ENTRY_W-1:0]          mem [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0]  wr_ptr_q, rd_ptr_q;
  logic [LEVEL_W-1:0]          ram_cnt_q, level;
  logic [ENTRY_W-1:0]          out_q;
  logic                        out_valid_q;
  logic                        fifo_full, pop, push_ok, drop, out_free, bypass, ram_we, ram_re;

  genvar gi;

`ifdef ADC_TEST_PATTERN_EN
  // Counting pattern: channel c carries sample_count + c, channel 0 in the MSBs
  logic [WORD_W-1:0] pattern_word;
  for (gi = 0; gi < NUM_CH; gi++) begin : g_pattern
    assign pattern_word[WORD_W-1-gi*SAMPLE_WIDTH -: SAMPLE_WIDTH] =
      SAMPLE_WIDTH'(sample_count_q + 32'(gi));
  end
  assign in_word = test_pattern_sel ? pattern_word : adc_data;
`else
  logic unused_test_pattern_sel;
  assign unused_test_pattern_sel = test_pattern_sel;
  assign in_word = adc_data;
`endif

  // Packer lane insert: the lane addressed by pack_idx_q takes the new word,
  // lane 0 being the MSB lane so the first word of a beat lands on top.
  for (gi = 0; gi < LANES; gi++) begin : g_lane
    assign pack_data_d[AXI_DATA_WIDTH-1-gi*WORD_W -: WORD_W] =
      (pack_idx_q == IDX_W'(gi)) ? in_word
                                 : pack_data_q[AXI_DATA_WIDTH-1-gi*WORD_W -: WORD_W];
  end

  // Byte enables for a partial beat: a byte is kept if its lane was filled
  for (gi = 0; gi < KEEP_W; gi++) begin : g_keep
    localparam int BYTE_LANE = (AXI_DATA_WIDTH - 1 - 8 * gi) / WORD_W;
    assign partial_keep[gi] = (BYTE_LANE < int'(pack_idx_q));
  end

  // Beat assembly and selection of the single beat pushed this cycle
  always_comb begin
    accept        = (state_q == S_RUN) && en_rr_q && adc_valid;
    tag_beat      = '0;
    tag_beat[AXI_DATA_WIDTH-1 -: 32] = sample_count_q;
    tag_beat[WORD_W-1:0]             = in_word;
    complete      = accept && (tag_mode_q || (pack_idx_q == IDX_W'(LANES - 1)));
    complete_beat = tag_mode_q ? tag_beat : pack_data_d;
    frame_end     = (frame_len_q != '0) &&
                    (beat_cnt_q == frame_len_q - FRAME_LEN_WIDTH'(1));
    partial_valid = !tag_mode_q && (pack_idx_q != '0);

    push_req  = 1'b0;
    push_beat = '0;
    push_last = 1'b0;
    push_keep = '1;
    case (state_q)
      S_RUN: begin
        if (complete) begin
          if (held_valid_q) begin
            push_req  = 1'b1;
            push_beat = held_q;
            push_last = held_last_q;
          end else if (frame_end) begin
            push_req  = 1'b1;
            push_beat = complete_beat;
            push_last = 1'b1;
          end
        end else if (held_valid_q && held_last_q) begin
          // frame-end beat parked behind the previous held beat goes out now
          push_req  = 1'b1;
          push_beat = held_q;
          push_last = 1'b1;
        end
      end
      S_FLUSH: begin
        if (held_valid_q) begin
          push_req  = 1'b1;
          push_beat = held_q;
          push_last = held_last_q || !partial_valid;
        end else if (partial_valid) begin
          push_req  = 1'b1;
          push_beat = pack_data_q;
          push_last = 1'b1;
          push_keep = partial_keep;
        end
      end
      default: ;
    endcase
    push_entry = {push_last, sof_q, push_keep, push_beat};
  end

  // Two-flop synchroniser for the capture enable
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      en_r_q  <= 1'b0;
      en_rr_q <= 1'b0;
    end else begin
      en_r_q  <= adc_enable;
      en_rr_q <= en_r_q;
    end
  end

  // Capture FSM: arming, packing, holding register, framing and flush.
  // Transitions use en_r_q so the state changes on the same edge en_rr_q does.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q        <= S_IDLE;
      frame_len_q    <= '0;
      tag_mode_q     <= 1'b0;
      beat_cnt_q     <= '0;
      sample_count_q <= '0;
      pack_data_q    <= '0;
      pack_idx_q     <= '0;
      held_q         <= '0;
      held_valid_q   <= 1'b0;
      held_last_q    <= 1'b0;
      sof_q          <= 1'b0;
    end else begin
      if (push_req) sof_q <= push_last;
      case (state_q)
        S_IDLE: begin
          if (en_r_q && !en_rr_q) begin
            state_q        <= S_RUN;
            frame_len_q    <= frame_len;
            tag_mode_q     <= tag_mode;
            beat_cnt_q     <= '0;
            sample_count_q <= '0;
            pack_data_q    <= '0;
            pack_idx_q     <= '0;
            held_valid_q   <= 1'b0;
            held_last_q    <= 1'b0;
            sof_q          <= 1'b1;
          end
        end
        S_RUN: begin
          if (accept) sample_count_q <= sample_count_q + 32'd1;
          if (accept && !tag_mode_q) begin
            if (complete) begin
              pack_data_q <= '0;
              pack_idx_q  <= '0;
            end else begin
              pack_data_q <= pack_data_d;
              pack_idx_q  <= pack_idx_q + IDX_W'(1);
            end
          end
          if (complete) begin
            beat_cnt_q <= frame_end ? '0 : beat_cnt_q + FRAME_LEN_WIDTH'(1);
            if (frame_end && !held_valid_q) begin
              held_valid_q <= 1'b0;
              held_last_q  <= 1'b0;
            end else begin
              held_q       <= complete_beat;
              held_valid_q <= 1'b1;
              held_last_q  <= frame_end;
            end
          end else if (held_valid_q && held_last_q) begin
            held_valid_q <= 1'b0;
            held_last_q  <= 1'b0;
          end
          if (!en_r_q) state_q <= S_FLUSH;
        end
        S_FLUSH: begin
          if (held_valid_q) begin
            held_valid_q <= 1'b0;
            held_last_q  <= 1'b0;
            if (!partial_valid) state_q <= S_IDLE;
          end else begin
            pack_data_q <= '0;
            pack_idx_q  <= '0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // FIFO control: the output register is the head entry; it is loaded from
  // the array, or directly from the push when the array is empty, so a push
  // is visible on the bus one cycle later.
  always_comb begin
    level     = ram_cnt_q + LEVEL_W'(out_valid_q);
    fifo_full = (level == LEVEL_W'(DEPTH));
    pop       = out_valid_q && m_axis.tready;
    push_ok   = push_req && (!fifo_full || pop);
    drop      = push_req && !push_ok;
    out_free  = !out_valid_q || pop;
    bypass    = push_ok && out_free && (ram_cnt_q == '0);
    ram_we    = push_ok && !bypass;
    ram_re    = out_free && (ram_cnt_q != '0);
  end

  // FIFO array write port
  always_ff @(posedge aclk) begin
    if (ram_we) mem[wr_ptr_q] <= push_entry;
  end

  // FIFO pointers, occupancy, registered head read and sticky overflow
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      ram_cnt_q   <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      if (ram_we) wr_ptr_q <= wr_ptr_q + FIFO_DEPTH_LOG2'(1);
      if (ram_re) rd_ptr_q <= rd_ptr_q + FIFO_DEPTH_LOG2'(1);
      ram_cnt_q <= ram_cnt_q + LEVEL_W'(ram_we) - LEVEL_W'(ram_re);
      if (ram_re) begin
        out_q       <= mem[rd_ptr_q];
        out_valid_q <= 1'b1;
      end else if (bypass) begin
        out_q       <= push_entry;
        out_valid_q <= 1'b1;
      end else if (pop) begin
        out_valid_q <= 1'b0;
      end
      if (drop)              overflow_q <= 1'b1;
      else if (overflow_clr) overflow_q <= 1'b0;
    end
  end

  assign m_axis.tdata  = out_q[AXI_DATA_WIDTH-1:0];
  assign m_axis.tkeep  = out_q[AXI_DATA_WIDTH +: KEEP_W];
  assign m_axis.tuser  = out_q[AXI_DATA_WIDTH + KEEP_W];
  assign m_axis.tlast  = out_q[AXI_DATA_WIDTH + KEEP_W + 1];
  assign m_axis.tvalid = out_valid_q;
  assign overflow      = overflow_q;
  assign sample_count  = sample_count_q;
  assign fifo_level    = level;
endmodule

// File: tb/tb_adc_sample_packetizer.sv
// Directed bench for adc_sample_packetizer (default parameters).
module tb_adc_sample_packetizer;
  localparam int AW = 64;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        adc_enable = 1'b0;
  logic        adc_valid = 1'b0;
  logic [31:0] adc_data = '0;
  logic [15:0] frame_len = '0;
  logic        tag_mode = 1'b0;
  logic        test_pattern_sel = 1'b0;
  logic        overflow_clr = 1'b0;
  logic        overflow;
  logic [31:0] sample_count;
  logic [9:0]  fifo_level;

  adc_sample_packetizer_if #(.AXI_DATA_WIDTH(AW)) m_axis ();

  adc_sample_packetizer dut (
    .aclk             (aclk),
    .aresetn          (aresetn),
    .adc_enable       (adc_enable),
    .adc_data         (adc_data),
    .adc_valid        (adc_valid),
    .frame_len        (frame_len),
    .tag_mode         (tag_mode),
    .test_pattern_sel (test_pattern_sel),
    .m_axis           (m_axis),
    .overflow         (overflow),
    .overflow_clr     (overflow_clr),
    .sample_count     (sample_count),
    .fifo_level       (fifo_level)
  );

  typedef struct {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    logic        user;
  } beat_t;

  beat_t beats[$];
  int checks = 0;
  int failures = 0;

  always #5 aclk = ~aclk;

  // Record every handshaken beat, sampled mid-cycle
  always @(negedge aclk) begin
    if (m_axis.tvalid === 1'b1 && m_axis.tready === 1'b1)
      beats.push_back('{m_axis.tdata, m_axis.tkeep, m_axis.tlast, m_axis.tuser});
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge aclk);
      #1;
    end
  endtask

  task automatic start_capture(input logic tm, input logic [15:0] fl);
    tag_mode   = tm;
    frame_len  = fl;
    adc_enable = 1'b1;
    tick(2);
  endtask

  task automatic send_words(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      adc_valid = 1'b1;
      adc_data  = base + 32'(i);
      tick();
    end
    adc_valid = 1'b0;
  endtask

  task automatic stop_capture();
    adc_enable = 1'b0;
    tick(8);
  endtask

  initial begin
    logic [31:0] base;
    m_axis.tready = 1'b0;

    // Reset state
    tick(3);
    chk("rst_tvalid", 64'(m_axis.tvalid), 64'd0);
    chk("rst_tdata", m_axis.tdata, 64'd0);
    chk("rst_tkeep", 64'(m_axis.tkeep), 64'd0);
    chk("rst_tlast", 64'(m_axis.tlast), 64'd0);
    chk("rst_tuser", 64'(m_axis.tuser), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_sample_count", 64'(sample_count), 64'd0);
    chk("rst_fifo_level", 64'(fifo_level), 64'd0);
    aresetn = 1'b1;
    tick(2);

    // Pack mode, frame_len=4, 16 words
    m_axis.tready = 1'b1;
    beats.delete();
    base = 32'h1000_0000;
    start_capture(1'b0, 16'd4);
    send_words(base, 16);
    tick(4);
    stop_capture();
    chk("t1_beats", 64'(beats.size()), 64'd8);
    for (int k = 0; k < 8 && k < beats.size(); k++) begin
      chk($sformatf("t1_data%0d", k), beats[k].data, {base + 32'(2*k), base + 32'(2*k+1)});
      chk($sformatf("t1_keep%0d", k), 64'(beats[k].keep), 64'hFF);
      chk($sformatf("t1_last%0d", k), 64'(beats[k].last), 64'(k == 3 || k == 7));
      chk($sformatf("t1_user%0d", k), 64'(beats[k].user), 64'(k == 0 || k == 4));
    end
    chk("t1_sample_count", 64'(sample_count), 64'd16);
    chk("t1_fifo_level", 64'(fifo_level), 64'd0);

    // Tag mode, unbounded frame, 3 words then disable
    beats.delete();
    base = 32'h2000_0000;
    start_capture(1'b1, 16'd0);
    send_words(base, 3);
    stop_capture();
    chk("t2_beats", 64'(beats.size()), 64'd3);
    for (int k = 0; k < 3 && k < beats.size(); k++) begin
      chk($sformatf("t2_data%0d", k), beats[k].data, {32'(k), base + 32'(k)});
      chk($sformatf("t2_last%0d", k), 64'(beats[k].last), 64'(k == 2));
      chk($sformatf("t2_user%0d", k), 64'(beats[k].user), 64'(k == 0));
    end
    chk("t2_state_idle", 64'(int'(dut.state_q)), 64'd0);

    // Pack mode, 5 words then disable: partial flush beat
    beats.delete();
    base = 32'h3000_0000;
    start_capture(1'b0, 16'd0);
    send_words(base, 5);
    stop_capture();
    chk("t3_beats", 64'(beats.size()), 64'd3);
    if (beats.size() == 3) begin
      chk("t3_data0", beats[0].data, {base, base + 32'd1});
      chk("t3_user0", 64'(beats[0].user), 64'd1);
      chk("t3_last1", 64'(beats[1].last), 64'd0);
      chk("t3_data2", beats[2].data, {base + 32'd4, 32'h0});
      chk("t3_keep2", 64'(beats[2].keep), 64'hF0);
      chk("t3_last2", 64'(beats[2].last), 64'd1);
      chk("t3_keep1", 64'(beats[1].keep), 64'hFF);
    end

    // Backpressure: 516 tagged beats into a 512-deep FIFO
    m_axis.tready = 1'b0;
    beats.delete();
    base = 32'h4000_0000;
    start_capture(1'b1, 16'd0);
    send_words(base, 516);
    tick(4);
    chk("t4_fifo_full", 64'(fifo_level), 64'd512);
    chk("t4_overflow", 64'(overflow), 64'd1);
    chk("t4_tvalid", 64'(m_axis.tvalid), 64'd1);
    chk("t4_head_stable", m_axis.tdata, {32'd0, base});
    chk("t4_sample_count", 64'(sample_count), 64'd516);
    m_axis.tready = 1'b1;
    tick(520);
    chk("t4_drained", 64'(beats.size()), 64'd512);
    for (int k = 0; k < 512 && k < beats.size(); k++)
      chk($sformatf("t4_data%0d", k), beats[k].data, {32'(k), base + 32'(k)});
    chk("t4_level_empty", 64'(fifo_level), 64'd0);
    chk("t4_overflow_sticky", 64'(overflow), 64'd1);
    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0;
    chk("t4_overflow_clr", 64'(overflow), 64'd0);
    beats.delete();
    stop_capture();
    chk("t4_flush_beats", 64'(beats.size()), 64'd1);
    if (beats.size() == 1) begin
      chk("t4_flush_data", beats[0].data, {32'd515, base + 32'd515});
      chk("t4_flush_last", 64'(beats[0].last), 64'd1);
    end

    // Asynchronous reset mid-frame
    m_axis.tready = 1'b0;
    beats.delete();
    base = 32'h5000_0000;
    start_capture(1'b0, 16'd4);
    send_words(base, 5);
    tick();
    chk("t5_pre_tvalid", 64'(m_axis.tvalid), 64'd1);
    chk("t5_pre_count", 64'(sample_count), 64'd5);
    #2;
    aresetn    = 1'b0;
    adc_enable = 1'b0;
    #1;
    chk("t5_rst_tvalid", 64'(m_axis.tvalid), 64'd0);
    chk("t5_rst_level", 64'(fifo_level), 64'd0);
    chk("t5_rst_count", 64'(sample_count), 64'd0);
    chk("t5_rst_overflow", 64'(overflow), 64'd0);
    tick(2);
    aresetn = 1'b1;
    m_axis.tready = 1'b1;
    tick();
    beats.delete();
    base = 32'h6000_0000;
    start_capture(1'b0, 16'd4);
    send_words(base, 2);
    stop_capture();
    chk("t5_beats", 64'(beats.size()), 64'd1);
    if (beats.size() == 1) begin
      chk("t5_data", beats[0].data, {base, base + 32'd1});
      chk("t5_user", 64'(beats[0].user), 64'd1);
      chk("t5_last", 64'(beats[0].last), 64'd1);
    end

    // Test pattern select
    beats.delete();
    base = 32'h7000_0000;
    test_pattern_sel = 1'b1;
    start_capture(1'b0, 16'd0);
    send_words(base, 2);
    stop_capture();
    test_pattern_sel = 1'b0;
    chk("t6_beats", 64'(beats.size()), 64'd1);
    if (beats.size() == 1) begin
`ifdef ADC_TEST_PATTERN_EN
      chk("t6_pattern", beats[0].data, 64'h0000_0001_0001_0002);
`else
      chk("t6_no_pattern", beats[0].data, {base, base + 32'd1});
`endif
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
